hps_mpu_event_bridge: RTL and testbench

HPS_MPU_EVENT_BRIDGE -- requirements
Module: hps_mpu_event_bridge

---
 rtl/hps_evt_pkg.sv | 20 ++
 rtl/evt_sync2.sv | 24 ++
 rtl/hps_mpu_event_bridge.sv | 170 +++++++++++++++++
 tb/tb_hps_mpu_event_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_evt_pkg.sv
// Shared types and constants for the HPS MPU event bridge.
// The bridge FSM enum, the standby-WFI filter length and default parameter values.
package hps_evt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_GAP    = 2'd2
   } evt_state_e;

   localparam int WFI_FILT_LEN = 8;
   localparam int RUN_W        = $clog2(WFI_FILT_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WFI_FILT_LEN);

   localparam int DEF_NUM_SRC   = 4;
   localparam int DEF_NUM_CORES = 2;
   localparam int DEF_PULSE_LEN = 4;
   localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/evt_sync2.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset.
// Latency 2 cycles; no backpressure.
module evt_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/hps_mpu_event_bridge.sv
// Turns fabric wake-request edges into fixed-length eventi pulses to the HPS MPU and
// synchronizes HPS evento/standby status back. Optional WFI filter: MPU_EVT_WFI_FILTER_EN.
module hps_mpu_event_bridge
   import hps_evt_pkg::*;
#(
   parameter int NUM_SRC   = DEF_NUM_SRC,
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int PULSE_LEN = DEF_PULSE_LEN,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [NUM_SRC-1:0]   src_req,
   input  logic [NUM_SRC-1:0]   src_mask,
   input  logic                 clr_cnt,
   input  logic                 evento,
   input  logic [NUM_CORES-1:0] standbywfe,
   input  logic [NUM_CORES-1:0] standbywfi,
   output logic                 eventi,
   output logic [NUM_SRC-1:0]   pending,
   output logic                 evento_pulse,
   output logic [NUM_CORES-1:0] core_wfi,
   output logic [NUM_CORES-1:0] core_wfe,
   output logic [CNT_W-1:0]     wake_cnt
);

   localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

   evt_state_e           state_q, state_d;
   logic [7:0]           pcnt_q, pcnt_d;
   logic                 eventi_q, eventi_d;
   logic                 start;
   logic [NUM_SRC-1:0]   req_prev_q;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   src_edge;
   logic [CNT_W-1:0]     wake_cnt_q, wake_cnt_d;

   assign src_edge = src_req & ~req_prev_q & src_mask;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q  <= ST_IDLE;
         pcnt_q   <= '0;
         eventi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         eventi_q <= eventi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               state_d = ST_ASSERT;
               pcnt_d  = '0;
            end
         end
         ST_ASSERT: begin
            if (pcnt_q == PULSE_LAST) begin
               state_d = ST_GAP;
            end else begin
               pcnt_d = pcnt_q + 8'd1;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Edges seen in the launch cycle survive the clear so they earn their own pulse.
   always_comb begin
      start      = (state_q == ST_IDLE) && (state_d == ST_ASSERT);
      eventi_d   = (state_d == ST_ASSERT);
      pending_d  = (start ? '0 : pending_q) | src_edge;
      wake_cnt_d = wake_cnt_q;
      if (clr_cnt) begin
         wake_cnt_d = '0;
      end else if (start && (wake_cnt_q != '1)) begin
         wake_cnt_d = wake_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         req_prev_q <= '0;
         pending_q  <= '0;
         wake_cnt_q <= '0;
      end else begin
         req_prev_q <= src_req;
         pending_q  <= pending_d;
         wake_cnt_q <= wake_cnt_d;
      end
   end

   assign eventi   = eventi_q;
   assign pending  = pending_q;
   assign wake_cnt = wake_cnt_q;

   logic                 evento_s;
   logic                 evento_prev_q;
   logic                 evento_pulse_q;
   logic [NUM_CORES-1:0] wfe_s;
   logic [NUM_CORES-1:0] wfi_s;

   evt_sync2 u_sync_evento (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .d_i    (evento),
      .q_o    (evento_s)
   );

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core_sync
      evt_sync2 u_sync_wfe (
         .clk_i  (clk_clk),
         .rst_ni (reset_reset_n),
         .d_i    (standbywfe[c]),
         .q_o    (wfe_s[c])
      );
      evt_sync2 u_sync_wfi (
         .clk_i  (clk_clk),
         .rst_ni (reset_reset_n),
         .d_i    (standbywfi[c]),
         .q_o    (wfi_s[c])
      );
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         evento_prev_q  <= 1'b0;
         evento_pulse_q <= 1'b0;
      end else begin
         evento_prev_q  <= evento_s;
         evento_pulse_q <= evento_s & ~evento_prev_q;
      end
   end

   assign evento_pulse = evento_pulse_q;
   assign core_wfe     = wfe_s;

`ifdef MPU_EVT_WFI_FILTER_EN
   // Count consecutive synchronized-high cycles; any low cycle drops core_wfi at once.
   for (genvar c = 0; c < NUM_CORES; c++) begin : g_wfi_filt
      logic [RUN_W-1:0] run_q, run_d;

      always_comb begin
         run_d = '0;
         if (wfi_s[c]) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
         end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            run_q <= '0;
         end else begin
            run_q <= run_d;
         end
      end

      assign core_wfi[c] = wfi_s[c] & (run_q == RUN_MAX);
   end
`else
   assign core_wfi = wfi_s;
`endif

endmodule

// File: tb/tb_hps_mpu_event_bridge.sv
// Directed self-checking bench for hps_mpu_event_bridge (default parameters plus a CNT_W=4 copy).
module tb_hps_mpu_event_bridge;

   logic       clk_clk = 1'b0;
   logic       reset_reset_n;
   logic [3:0] src_req;
   logic [3:0] src_mask;
   logic       clr_cnt;
   logic       evento;
   logic [1:0] standbywfe;
   logic [1:0] standbywfi;

   logic        eventi, evento_pulse;
   logic [3:0]  pending;
   logic [1:0]  core_wfi, core_wfe;
   logic [15:0] wake_cnt;

   logic        eventi4, evento_pulse4;
   logic [3:0]  pending4;
   logic [1:0]  core_wfi4, core_wfe4;
   logic [3:0]  wake_cnt4;

   int checks   = 0;
   int failures = 0;
   int npulse;

   always #5 clk_clk = ~clk_clk;

   hps_mpu_event_bridge dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .src_req       (src_req),
      .src_mask      (src_mask),
      .clr_cnt       (clr_cnt),
      .evento        (evento),
      .standbywfe    (standbywfe),
      .standbywfi    (standbywfi),
      .eventi        (eventi),
      .pending       (pending),
      .evento_pulse  (evento_pulse),
      .core_wfi      (core_wfi),
      .core_wfe      (core_wfe),
      .wake_cnt      (wake_cnt)
   );

   hps_mpu_event_bridge #(.CNT_W(4)) dut_c4 (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .src_req       (src_req),
      .src_mask      (src_mask),
      .clr_cnt       (clr_cnt),
      .evento        (evento),
      .standbywfe    (standbywfe),
      .standbywfi    (standbywfi),
      .eventi        (eventi4),
      .pending       (pending4),
      .evento_pulse  (evento_pulse4),
      .core_wfi      (core_wfi4),
      .core_wfe      (core_wfe4),
      .wake_cnt      (wake_cnt4)
   );

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_reset_n = 1'b0;
      src_req       = 4'h0;
      src_mask      = 4'hF;
      clr_cnt       = 1'b0;
      evento        = 1'b1;
      standbywfe    = 2'b11;
      standbywfi    = 2'b11;

      // Reset state, with async inputs toggled to show synchronizers are held
      step(); step(); step();
      chk("rst_eventi", eventi, 0);
      chk("rst_pending", pending, 0);
      chk("rst_wake_cnt", wake_cnt, 0);
      chk("rst_wake_cnt4", wake_cnt4, 0);
      chk("rst_evento_pulse", evento_pulse, 0);
      chk("rst_core_wfi", core_wfi, 0);
      chk("rst_core_wfe", core_wfe, 0);
      evento = 1'b0; standbywfe = 2'b00; standbywfi = 2'b00;
      reset_reset_n = 1'b1;
      repeat (4) step();

      // Basic pulse: edge in cycle c -> pending c+1, eventi c+2..c+5, gap c+6
      src_req = 4'b0001;
      step();
      chk("b_pending_c1", pending, 4'b0001);
      chk("b_eventi_c1", eventi, 0);
      step();
      chk("b_eventi_c2", eventi, 1);
      chk("b_pending_c2", pending, 0);
      chk("b_wake_c2", wake_cnt, 1);
      src_req = 4'b0111; src_mask = 4'b1011;
      step();
      chk("b_pending_c3", pending, 4'b0010);
      chk("b_eventi_c3", eventi, 1);
      step(); step();
      chk("b_eventi_c5", eventi, 1);
      step();
      chk("b_eventi_gap", eventi, 0);
      src_mask = 4'hF;
      step();
      chk("b_eventi_idle", eventi, 0);
      chk("b_pending_idle", pending, 4'b0010);
      step();
      chk("b_eventi_2nd", eventi, 1);
      chk("b_wake_2nd", wake_cnt, 2);
      chk("b_pending_2nd", pending, 0);
      repeat (6) step();
      chk("b_masked_no_pulse", eventi, 0);
      chk("b_wake_after", wake_cnt, 2);

      // Edge in the IDLE->ASSERT cycle survives the clear
      src_req = 4'b0000;
      step(); step();
      src_req = 4'b0001;
      step();
      chk("s_pending_d1", pending, 4'b0001);
      src_req = 4'b1001;
      step();
      chk("s_eventi_d2", eventi, 1);
      chk("s_pending_d2", pending, 4'b1000);
      chk("s_wake_d2", wake_cnt, 3);
      repeat (4) step();
      chk("s_eventi_gap", eventi, 0);
      chk("s_pending_gap", pending, 4'b1000);
      step(); step();
      chk("s_eventi_d8", eventi, 1);
      chk("s_pending_d8", pending, 0);
      chk("s_wake_d8", wake_cnt, 4);
      repeat (6) step();
      src_req = 4'b0000;
      step();

      // evento held 5 cycles -> single strobe 3 cycles after the edge
      evento = 1'b1;
      npulse = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 5) evento = 1'b0;
         step();
         if (k == 3) chk("e_pulse_at3", evento_pulse, 1);
         if (evento_pulse === 1'b1) npulse++;
      end
      chk("e_pulse_count", npulse, 1);

`ifndef MPU_EVT_WFI_FILTER_EN
      standbywfi = 2'b01; standbywfe = 2'b10;
      step();
      chk("w_wfi_c1", core_wfi, 2'b00);
      step();
      chk("w_wfi_c2", core_wfi, 2'b01);
      chk("w_wfe_c2", core_wfe, 2'b10);
      standbywfi = 2'b00;
      step();
      chk("w_wfi_hold", core_wfi, 2'b01);
      step();
      chk("w_wfi_drop", core_wfi, 2'b00);
`else
      standbywfi = 2'b01; standbywfe = 2'b10;
      npulse = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 8) standbywfi = 2'b00;
         step();
         if (core_wfi[0] === 1'b1) npulse++;
      end
      chk("f_short_no_wfi", npulse, 0);
      chk("f_wfe", core_wfe, 2'b10);
      standbywfi = 2'b01;
      repeat (9) step();
      chk("f_wfi_g9", core_wfi, 2'b00);
      step();
      chk("f_wfi_g10", core_wfi, 2'b01);
      standbywfi = 2'b00;
      step();
      chk("f_wfi_g11", core_wfi, 2'b01);
      step();
      chk("f_wfi_drop", core_wfi, 2'b00);
`endif
      standbywfe = 2'b10;

      // Counter clear and saturation (CNT_W=4 copy saturates at 15)
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("c_clr", wake_cnt, 0);
      chk("c_clr4", wake_cnt4, 0);
      for (int i = 0; i < 20; i++) begin
         src_req = 4'b0001;
         step();
         src_req = 4'b0000;
         repeat (7) step();
      end
      chk("c_wake20", wake_cnt, 20);
      chk("c_wake4_sat", wake_cnt4, 15);
      src_req = 4'b0001;
      step();
      src_req = 4'b0000; clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("c_clr_eventi", eventi, 1);
      chk("c_clr_wins", wake_cnt, 0);
      chk("c_clr_wins4", wake_cnt4, 0);

      // Async reset mid-ASSERT, with a held request counting as an edge afterwards
      src_req = 4'b0010;
      step();
      chk("r_pending_pre", pending, 4'b0010);
      chk("r_eventi_pre", eventi, 1);
      #3;
      reset_reset_n = 1'b0;
      #1;
      chk("r_eventi_async", eventi, 0);
      chk("r_pending_async", pending, 0);
      chk("r_wfe_async", core_wfe, 0);
      @(negedge clk_clk);
      #1;
      reset_reset_n = 1'b1;
      step();
      chk("r_held_edge", pending, 4'b0010);
      step();
      chk("r_eventi_after", eventi, 1);
      chk("r_wake_after", wake_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
